wb_regfile_scoreboard: RTL and testbench

//  - Consumer end of the MEM/WB writeback interface: the LC-3b register file plus an in-flight write scoreboard.
//  - Accepts the writeback triple (dest, regfilemux value, load_regfile), qualified by the pipeline-advance strobe.
//  - Supplies two decode-stage read ports with same-cycle write-through bypass.
//  - Tracks the number of outstanding writes per register and raises RAW hazard flags so decode can stall.

---
 rtl/wb_regfile_scoreboard_if.sv | 18 +
 rtl/wb_regfile_scoreboard.sv | 73 +++++++
 tb/tb_wb_regfile_scoreboard.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_scoreboard_if.sv
// wb_regfile_scoreboard_if: MEM/WB writeback bus into the register file.
// Signals:
//   adv   pipeline advance strobe (mem_resp), qualifies the rest
//   load  writeback enable (load_regfile)
//   dest  destination register index
//   data  writeback data (regfilemux_out)
// Modports: master drives the bus, slave (register file) consumes it.
interface wb_regfile_scoreboard_if #(
    parameter int IW = 3,
    parameter int DW = 16
);
    logic          adv;
    logic          load;
    logic [IW-1:0] dest;
    logic [DW-1:0] data;
    modport master (output adv, load, dest, data);
    modport slave  (input  adv, load, dest, data);
endinterface

// File: rtl/wb_regfile_scoreboard.sv
// wb_regfile_scoreboard: LC-3b register file with write-through bypass and per-register in-flight write scoreboard.
// Ports:
//   clk, reset_n         rising-edge clock, asynchronous active-low reset
//   wb                   writeback bus (slave): adv, load, dest, data
//   iss_adv, iss_load    decode-to-execute advance and "writes a register"
//   iss_dest             destination of the instruction leaving decode
//   flush                squash everything younger than MEM/WB
//   src_a, src_b         decode source indices
//   rdata_a, rdata_b     combinational read data with bypass
//   hazard_a, hazard_b   source has an outstanding write not yet visible
//   sb_err               sticky counter overflow/underflow
module wb_regfile_scoreboard #(
    parameter int NUM_REGS     = 8,
    parameter int DATA_W       = 16,
    parameter int MAX_INFLIGHT = 3
) (
    input  logic                        clk,
    input  logic                        reset_n,
    wb_regfile_scoreboard_if.slave      wb,
    input  logic                        iss_adv,
    input  logic                        iss_load,
    input  logic [$clog2(NUM_REGS)-1:0] iss_dest,
    input  logic                        flush,
    input  logic [$clog2(NUM_REGS)-1:0] src_a,
    input  logic [$clog2(NUM_REGS)-1:0] src_b,
    output logic [DATA_W-1:0]           rdata_a,
    output logic [DATA_W-1:0]           rdata_b,
    output logic                        hazard_a,
    output logic                        hazard_b,
    output logic                        sb_err
);
    localparam int IW = $clog2(NUM_REGS);
    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0] CMAX = CW'(MAX_INFLIGHT);
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [CW-1:0]     cnt  [NUM_REGS];
    logic [NUM_REGS-1:0] err_v;
    logic wb_fire, inc;
    assign wb_fire = wb.adv & wb.load;
    assign inc     = iss_adv & iss_load;
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        logic [DATA_W-1:0] q;
        logic [CW-1:0]     c;
        logic              inc_i, dec_i;
        // flush drops the same-cycle issue; the MEM/WB retire still writes data
        assign inc_i    = inc & ~flush & (iss_dest == IW'(i));
        assign dec_i    = wb_fire & (wb.dest == IW'(i));
        assign err_v[i] = ~flush & ((inc_i & ~dec_i & (c == CMAX)) | (dec_i & ~inc_i & (c == '0)));
        assign regs[i]  = q;
        assign cnt[i]   = c;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                q <= '0;
                c <= '0;
            end else begin
                if (dec_i) q <= wb.data;
                c <= flush ? '0 :
                     (inc_i == dec_i) ? c :
                     inc_i ? ((c == CMAX) ? c : c + CW'(1)) :
                     ((c == '0) ? c : c - CW'(1));
            end
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sb_err <= 1'b0;
        else if (|err_v) sb_err <= 1'b1;
    end
    assign rdata_a = (wb_fire && wb.dest == src_a) ? wb.data : regs[src_a];
    assign rdata_b = (wb_fire && wb.dest == src_b) ? wb.data : regs[src_b];
    // a last outstanding write retiring this cycle is already covered by the bypass
    assign hazard_a = (cnt[src_a] != '0) & ~(wb_fire & (wb.dest == src_a) & (cnt[src_a] == CW'(1)));
    assign hazard_b = (cnt[src_b] != '0) & ~(wb_fire & (wb.dest == src_b) & (cnt[src_b] == CW'(1)));
endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// tb_wb_regfile_scoreboard: directed vector table, reset/error sequences and randomized model check.
module tb_wb_regfile_scoreboard;
    typedef struct {
        logic        wa, wl;
        logic [2:0]  wd;
        logic [15:0] wdat;
        logic        ia, il;
        logic [2:0]  id;
        logic        fl;
        logic [2:0]  sa, sb;
        logic [15:0] ea, eb;
        logic        eha, ehb, eerr;
    } vec_t;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic iss_adv = 1'b0, iss_load = 1'b0, flush = 1'b0;
    logic [2:0] iss_dest = '0, src_a = '0, src_b = '0;
    logic [15:0] rdata_a, rdata_b;
    logic hazard_a, hazard_b, sb_err;
    int vectors = 0;
    int miscompares = 0;
    int cnt_m [8];
    logic [15:0] regs_m [8];
    bit err_m;
    vec_t tbl [$];
    wb_regfile_scoreboard_if wbi ();
    wb_regfile_scoreboard dut (
        .clk(clk), .reset_n(reset_n), .wb(wbi.slave),
        .iss_adv(iss_adv), .iss_load(iss_load), .iss_dest(iss_dest), .flush(flush),
        .src_a(src_a), .src_b(src_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
        .hazard_a(hazard_a), .hazard_b(hazard_b), .sb_err(sb_err)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic void mdl_reset();
        foreach (cnt_m[r]) begin
            cnt_m[r] = 0;
            regs_m[r] = '0;
        end
        err_m = 1'b0;
    endfunction
    // hazard means writes remain outstanding after this cycle's retire
    function automatic vec_t mdl_expect(input vec_t v);
        vec_t e = v;
        bit fire = v.wa & v.wl;
        e.ea   = (fire && v.wd == v.sa) ? v.wdat : regs_m[v.sa];
        e.eb   = (fire && v.wd == v.sb) ? v.wdat : regs_m[v.sb];
        e.eha  = cnt_m[v.sa] > ((fire && v.wd == v.sa) ? 1 : 0);
        e.ehb  = cnt_m[v.sb] > ((fire && v.wd == v.sb) ? 1 : 0);
        e.eerr = err_m;
        return e;
    endfunction
    function automatic void mdl_step(input vec_t v);
        bit fire = v.wa & v.wl;
        bit inc = v.ia & v.il;
        if (fire) regs_m[v.wd] = v.wdat;
        if (v.fl) begin
            foreach (cnt_m[r]) cnt_m[r] = 0;
        end else if (!(inc && fire && v.id == v.wd)) begin
            if (inc) begin
                if (cnt_m[v.id] == 3) err_m = 1'b1;
                else cnt_m[v.id]++;
            end
            if (fire) begin
                if (cnt_m[v.wd] == 0) err_m = 1'b1;
                else cnt_m[v.wd]--;
            end
        end
    endfunction
    task automatic apply(input vec_t v);
        wbi.adv = v.wa;
        wbi.load = v.wl;
        wbi.dest = v.wd;
        wbi.data = v.wdat;
        iss_adv = v.ia;
        iss_load = v.il;
        iss_dest = v.id;
        flush = v.fl;
        src_a = v.sa;
        src_b = v.sb;
        @(negedge clk);
        chk("rdata_a", rdata_a, v.ea);
        chk("rdata_b", rdata_b, v.eb);
        chk("hazard_a", 16'(hazard_a), 16'(v.eha));
        chk("hazard_b", 16'(hazard_b), 16'(v.ehb));
        chk("sb_err", 16'(sb_err), 16'(v.eerr));
        @(posedge clk);
        mdl_step(v);
        #1;
    endtask
    function automatic vec_t idle(input logic [2:0] sa, input logic [2:0] sb);
        vec_t v = '{0, 0, 0, 0, 0, 0, 0, 0, sa, sb, 0, 0, 0, 0, 0};
        return v;
    endfunction
    initial begin
        vec_t v;
        wbi.adv = 1'b0;
        wbi.load = 1'b0;
        wbi.dest = '0;
        wbi.data = '0;
        mdl_reset();
        tbl.push_back('{0,0,0,16'h0000, 1,1,5, 0, 5,2, 16'h0000,16'h0000, 0,0,0});
        tbl.push_back('{1,1,5,16'hBEEF, 0,0,0, 0, 5,5, 16'hBEEF,16'hBEEF, 0,0,0});
        tbl.push_back('{0,0,0,16'h0000, 0,0,0, 0, 5,0, 16'hBEEF,16'h0000, 0,0,0});
        tbl.push_back('{0,1,5,16'h1234, 0,0,0, 0, 5,0, 16'hBEEF,16'h0000, 0,0,0});
        tbl.push_back('{0,0,0,16'h0000, 0,0,0, 0, 5,0, 16'hBEEF,16'h0000, 0,0,0});
        tbl.push_back('{0,0,0,16'h0000, 1,1,2, 0, 2,0, 16'h0000,16'h0000, 0,0,0});
        tbl.push_back('{0,0,0,16'h0000, 1,1,2, 0, 2,0, 16'h0000,16'h0000, 1,0,0});
        tbl.push_back('{1,1,2,16'h0022, 0,0,0, 0, 2,0, 16'h0022,16'h0000, 1,0,0});
        tbl.push_back('{1,1,2,16'h0033, 0,0,0, 0, 2,0, 16'h0033,16'h0000, 0,0,0});
        tbl.push_back('{0,0,0,16'h0000, 0,0,0, 0, 2,0, 16'h0033,16'h0000, 0,0,0});
        tbl.push_back('{0,0,0,16'h0000, 1,1,4, 0, 0,4, 16'h0000,16'h0000, 0,0,0});
        tbl.push_back('{1,1,4,16'h0044, 1,1,4, 0, 0,4, 16'h0000,16'h0044, 0,0,0});
        tbl.push_back('{0,0,0,16'h0000, 1,1,6, 0, 0,4, 16'h0000,16'h0044, 0,1,0});
        tbl.push_back('{1,1,6,16'h0066, 1,1,1, 0, 1,6, 16'h0000,16'h0066, 0,0,0});
        tbl.push_back('{0,0,0,16'h0000, 1,1,1, 0, 1,6, 16'h0000,16'h0066, 1,0,0});
        tbl.push_back('{0,0,0,16'h0000, 1,1,6, 0, 1,6, 16'h0000,16'h0066, 1,0,0});
        tbl.push_back('{1,1,6,16'h00AA, 1,1,1, 1, 6,1, 16'h00AA,16'h0000, 0,1,0});
        tbl.push_back('{0,0,0,16'h0000, 0,0,0, 0, 6,1, 16'h00AA,16'h0000, 0,0,0});
        tbl.push_back('{0,0,0,16'h0000, 0,0,0, 0, 4,2, 16'h0044,16'h0033, 0,0,0});
        tbl.push_back('{0,0,0,16'h0000, 1,1,7, 0, 7,6, 16'h0000,16'h00AA, 0,0,0});
        tbl.push_back('{0,0,0,16'h0000, 1,1,7, 0, 7,6, 16'h0000,16'h00AA, 1,0,0});
        tbl.push_back('{0,0,0,16'h0000, 1,1,7, 0, 7,6, 16'h0000,16'h00AA, 1,0,0});
        tbl.push_back('{0,0,0,16'h0000, 1,1,7, 0, 7,6, 16'h0000,16'h00AA, 1,0,0});
        tbl.push_back('{0,0,0,16'h0000, 0,0,0, 0, 7,6, 16'h0000,16'h00AA, 1,0,1});
        #1;
        chk("reset_hazard_a", 16'(hazard_a), 16'h0);
        chk("reset_sb_err", 16'(sb_err), 16'h0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        foreach (tbl[k]) apply(tbl[k]);
        // build cnt[3]=2 with R3 holding data, then reset mid-cycle
        apply('{0,0,0,16'h0000, 1,1,3, 0, 3,3, 16'h0000,16'h0000, 0,0,1});
        apply('{1,1,3,16'h3333, 1,1,3, 0, 3,3, 16'h3333,16'h3333, 0,0,1});
        apply('{0,0,0,16'h0000, 1,1,3, 0, 3,3, 16'h3333,16'h3333, 1,1,1});
        apply('{0,0,0,16'h0000, 0,0,0, 0, 3,3, 16'h3333,16'h3333, 1,1,1});
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_hazard_a", 16'(hazard_a), 16'h0);
        chk("midreset_rdata_a", rdata_a, 16'h0000);
        chk("midreset_sb_err", 16'(sb_err), 16'h0);
        mdl_reset();
        @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int r = 0; r < 8; r++) apply(idle(3'(r), 3'(7 - r)));
        apply('{1,1,0,16'h0F0F, 0,0,0, 0, 0,1, 16'h0F0F,16'h0000, 0,0,0});
        apply('{0,0,0,16'h0000, 0,0,0, 0, 0,1, 16'h0F0F,16'h0000, 0,0,1});
        // randomized traffic against the model, with periodic resets
        #1 reset_n = 1'b0;
        mdl_reset();
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n < 600; n++) begin
            if (n % 80 == 79) begin
                reset_n = 1'b0;
                mdl_reset();
                #2 reset_n = 1'b1;
            end
            v = idle(3'($urandom_range(7)), 3'($urandom_range(7)));
            v.wd   = 3'($urandom_range(7));
            v.wdat = 16'($urandom);
            v.wa   = ($urandom_range(3) != 0);
            v.wl   = (cnt_m[v.wd] > 0) ? ($urandom_range(3) != 0) : ($urandom_range(15) == 0);
            v.ia   = $urandom_range(1) == 1;
            v.il   = $urandom_range(3) != 0;
            v.id   = 3'($urandom_range(7));
            v.fl   = $urandom_range(15) == 0;
            if ($urandom_range(3) == 0) v.sa = v.wd;
            apply(mdl_expect(v));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
